// File: rtl/clock_group_reset_sequencer_pkg.sv
// clock_group_reset_sequencer_pkg
//   Shared types and helpers for the clock group reset sequencer.
//   - seq_state_e : sequencer FSM states
//   - clog2()     : constant ceiling-log2, used to size counters and indices
package clock_group_reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } seq_state_e;

   // Returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/clock_group_reset_sequencer_if.sv
// clock_group_reset_sequencer_if
//   Control/status bundle of the reset sequencer.
//   sw_reset_req : re-sequence request (honoured only while idle)
//   member_reset : per-member reset, 1 = held in reset
//   busy         : sequence in progress
//   seq_done     : all members released
//   master = requester/consumer side, slave = sequencer side.
interface clock_group_reset_sequencer_if #(
   parameter int NUM_MEMBERS = 6
);
   logic                   sw_reset_req;
   logic [NUM_MEMBERS-1:0] member_reset;
   logic                   busy;
   logic                   seq_done;

   modport master (
      output sw_reset_req,
      input  member_reset,
      input  busy,
      input  seq_done
   );

   modport slave (
      input  sw_reset_req,
      output member_reset,
      output busy,
      output seq_done
   );
endinterface

// File: rtl/clock_group_reset_sequencer_sync.sv
// reset_sync_chain
//   Reset synchroniser: asynchronous assert, synchronous deassert.
//   clk_i      : local clock
//   rst_i      : asynchronous active-high reset
//   released_o : 1 once a 1 has shifted through all STAGES flops
module reset_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic released_o
);
   logic [STAGES-1:0] sync_q;

   // Shift form that also works for a single stage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= (sync_q << 1) | STAGES'(1);
      end
   end

   assign released_o = sync_q[STAGES-1];
endmodule

// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer
//   Releases NUM_MEMBERS member resets one at a time (member 0 first) with a
//   fixed HOLD_CYCLES+1 cycle spacing after the global reset is synchronised,
//   and re-runs the sequence on a software request once idle.
//   clock : single clock for all logic
//   reset : asynchronous active-high global reset
//   bus   : sw_reset_req in; member_reset, busy, seq_done out (all registered)
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   SYNC    | waiting for the global reset to be synchronised
//   HOLD    | counting down the gap before the next member release
//   RELEASE | release member idx on the edge leaving this state
//   DONE    | all members released; idle, honours sw_reset_req
module clock_group_reset_sequencer
   import clock_group_reset_sequencer_pkg::*;
#(
   parameter int NUM_MEMBERS = 6,
   parameter int SYNC_STAGES = 3,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   clock_group_reset_sequencer_if.slave  bus
);
   localparam int CNT_W = clog2(HOLD_CYCLES + 1);
   localparam int IDX_W = (NUM_MEMBERS > 1) ? clog2(NUM_MEMBERS) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MEMBERS - 1);

   logic                   sync_released;
   seq_state_e             state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [IDX_W-1:0]       idx_q;
   logic [NUM_MEMBERS-1:0] member_reset_q;
   logic                   busy_q;
   logic                   seq_done_q;

   // The FSM's exit from SYNC acts as the last synchroniser flop, so the
   // chain itself is one stage shorter and HOLD is entered on edge
   // SYNC_STAGES after reset falls.
   reset_sync_chain #(
      .STAGES (SYNC_STAGES - 1)
   ) u_sync (
      .clk_i      (clock),
      .rst_i      (reset),
      .released_o (sync_released)
   );

   // HOLD_CYCLES >= 1, so the counter is at least 1 whenever HOLD is entered
   // and the decrement never goes below zero.
   assign cnt_d = cnt_q - CNT_W'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_SYNC;
         cnt_q          <= CNT_LOAD;
         idx_q          <= '0;
         member_reset_q <= '1;
         busy_q         <= 1'b1;
         seq_done_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_SYNC: begin
               if (sync_released) begin
                  state_q <= ST_HOLD;
                  cnt_q   <= CNT_LOAD;
                  idx_q   <= '0;
               end
            end
            ST_HOLD: begin
               cnt_q <= cnt_d;
               if (cnt_d == '0) begin
                  state_q <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               member_reset_q[idx_q] <= 1'b0;
               if (idx_q == IDX_LAST) begin
                  state_q    <= ST_DONE;
                  busy_q     <= 1'b0;
                  seq_done_q <= 1'b1;
               end else begin
                  state_q <= ST_HOLD;
                  idx_q   <= idx_q + IDX_W'(1);
                  cnt_q   <= CNT_LOAD;
               end
            end
            ST_DONE: begin
               if (bus.sw_reset_req) begin
                  state_q        <= ST_HOLD;
                  member_reset_q <= '1;
                  busy_q         <= 1'b1;
                  seq_done_q     <= 1'b0;
                  idx_q          <= '0;
                  cnt_q          <= CNT_LOAD;
               end
            end
            default: begin
               state_q <= ST_SYNC;
            end
         endcase
      end
   end

   assign bus.member_reset = member_reset_q;
   assign bus.busy         = busy_q;
   assign bus.seq_done     = seq_done_q;
endmodule
